planta_envase: RTL

- Cycle-accurate plant emulator for the bottling line.
- Sits on the far side of the main-FSM / sealing-FSM interface. It consumes the actuator outputs (motor, EV, vedação, descarte) and produces the sensor inputs (garrafa, sensor_de_nivel, sensor_cq).
- Lets the controller be run on the FPGA board and in simulation without physical sensors.
- Moves one bottle at a time through fill, seal and quality-check stations.

---
 rtl/planta_pkg.sv | 36 +++
 rtl/planta_contador_sat.sv | 29 ++
 rtl/planta_envase.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/planta_pkg.sv
// planta_pkg
// Shared definitions for the bottling-line plant emulator.
// Contents:
//   estado_t      plant state encoding (3 bits)
//   FALHA_*       bit positions inside the sticky fault vector
//   IDX_W, CNT_W  bottle index width and counter width
//   idx_seguinte  bottle index successor, wrapping after the last pattern entry
package planta_pkg;

    localparam int IDX_W       = 4;
    localparam int CNT_W       = 8;
    localparam int NUM_BOTTLES = 12;

    localparam int FALHA_OVERFLOW = 0;  // valve kept open past the overfill margin
    localparam int FALHA_SEQ      = 1;  // bottle moved unfilled or unsealed
    localparam int FALHA_CQ       = 2;  // discard decision disagrees with quality result

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TO_FILL = 3'd1,
        AT_FILL = 3'd2,
        TO_SEAL = 3'd3,
        AT_SEAL = 3'd4,
        TO_CQ   = 3'd5,
        AT_CQ   = 3'd6,
        EXIT    = 3'd7
    } estado_t;

    function automatic logic [IDX_W-1:0] idx_seguinte(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_BOTTLES - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/planta_contador_sat.sv
// planta_contador_sat
// Saturating up-counter with enable and synchronous clear.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high
//   clr    in   synchronous clear (priority over en)
//   en     in   count enable; holds at all-ones
//   count  out  current value
module planta_contador_sat
    import planta_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/planta_envase.sv
// planta_envase
// Cycle-accurate plant emulator for the bottling line. Consumes the
// controller's actuator commands and produces the sensor readings, moving
// one bottle at a time through fill, seal and quality-check stations.
// Plant time advances only on clk edges where tick = 1.
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high
//   tick             in   one-cycle plant time enable
//   motor            in   conveyor motor command
//   ev               in   fill valve command
//   ve               in   sealing actuator command
//   descarte         in   reject actuator command
//   garrafa          out  bottle present at a station
//   sensor_de_nivel  out  bottle at or above full level
//   sensor_cq        out  quality result (only meaningful in AT_CQ)
//   aprovadas        out  approved bottles, saturating
//   descartadas      out  rejected bottles, saturating
//   falha            out  sticky faults: [0] overflow, [1] sequence, [2] wrong decision
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no bottle on the line, waiting for the motor
// TO_FILL | bottle travelling to the fill station
// AT_FILL | bottle under the valve, level counts ev ticks
// TO_SEAL | bottle travelling to the sealing station
// AT_SEAL | bottle under the sealer, ve latches the seal flag
// TO_CQ   | bottle travelling to quality check
// AT_CQ   | quality result presented, waiting for accept or discard
// EXIT    | bottle leaving the line, back to IDLE on the next tick
module planta_envase
    import planta_pkg::*;
#(
    parameter int          TRAVEL_TICKS    = 3,
    parameter int          FILL_TICKS      = 4,
    parameter int          OVERFILL_MARGIN = 2,
    parameter logic [11:0] CQ_PATTERN      = 12'b1111_0111_1110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       motor,
    input  logic       ev,
    input  logic       ve,
    input  logic       descarte,
    output logic       garrafa,
    output logic       sensor_de_nivel,
    output logic       sensor_cq,
    output logic [7:0] aprovadas,
    output logic [7:0] descartadas,
    output logic [2:0] falha
);

    // The counter is already at 1 when a bottle leaves a station, so the
    // arrival tick is the one that finds it at TRAVEL_TICKS-1.
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] FILL_L      = CNT_W'(FILL_TICKS);
    localparam logic [CNT_W-1:0] LEVEL_MAX   = CNT_W'(FILL_TICKS + OVERFILL_MARGIN);
    // Padded to the full index range so any idx value selects a defined bit.
    localparam logic [15:0]      CQ_TAB      = {4'b0000, CQ_PATTERN};

    estado_t            state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               selada, selada_next;
    logic [2:0]         falha_next;
    logic [CNT_W-1:0]   travel, level, level_next;
    logic               travel_en, travel_clr;
    logic               level_en, level_clr;
    logic               apr_en, desc_en;
    logic               cq_bit;
    logic               garrafa_d, nivel_d, cq_d;

    planta_contador_sat #(.W(CNT_W)) u_travel (
        .clk   (clk),
        .reset (reset),
        .clr   (travel_clr),
        .en    (travel_en),
        .count (travel)
    );

    planta_contador_sat #(.W(CNT_W)) u_level (
        .clk   (clk),
        .reset (reset),
        .clr   (level_clr),
        .en    (level_en),
        .count (level)
    );

    planta_contador_sat #(.W(CNT_W)) u_aprovadas (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (apr_en),
        .count (aprovadas)
    );

    planta_contador_sat #(.W(CNT_W)) u_descartadas (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .en    (desc_en),
        .count (descartadas)
    );

    assign cq_bit = CQ_TAB[idx];

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        selada_next = selada;
        falha_next  = falha;
        travel_en   = 1'b0;
        travel_clr  = 1'b0;
        level_en    = 1'b0;
        level_clr   = 1'b0;
        apr_en      = 1'b0;
        desc_en     = 1'b0;

        if (tick) begin
            case (state)
                IDLE: begin
                    if (motor) begin
                        state_next = TO_FILL;
                        travel_en  = 1'b1;
                    end
                end

                TO_FILL, TO_SEAL, TO_CQ: begin
                    if (motor) begin
                        if (travel >= TRAVEL_LAST) begin
                            travel_clr = 1'b1;
                            case (state)
                                TO_FILL: state_next = AT_FILL;
                                TO_SEAL: state_next = AT_SEAL;
                                default: state_next = AT_CQ;
                            endcase
                        end else begin
                            travel_en = 1'b1;
                        end
                    end
                end

                AT_FILL: begin
                    // motor has priority over the valve on a shared tick
                    if (motor) begin
                        state_next = TO_SEAL;
                        travel_en  = 1'b1;
                        if (level < FILL_L) begin
                            falha_next[FALHA_SEQ] = 1'b1;
                        end
                    end else if (ev) begin
                        if (level >= LEVEL_MAX) begin
                            falha_next[FALHA_OVERFLOW] = 1'b1;
                        end else begin
                            level_en = 1'b1;
                        end
                    end
                end

                AT_SEAL: begin
                    // a seal on the departure tick still counts
                    if (ve) begin
                        selada_next = 1'b1;
                    end
                    if (motor) begin
                        state_next = TO_CQ;
                        travel_en  = 1'b1;
                        if (!(selada || ve)) begin
                            falha_next[FALHA_SEQ] = 1'b1;
                        end
                    end
                end

                AT_CQ: begin
                    if (descarte) begin
                        state_next  = EXIT;
                        desc_en     = 1'b1;
                        level_clr   = 1'b1;
                        selada_next = 1'b0;
                        if (cq_bit) begin
                            falha_next[FALHA_CQ] = 1'b1;
                        end
                    end else if (motor) begin
                        state_next  = EXIT;
                        apr_en      = 1'b1;
                        level_clr   = 1'b1;
                        selada_next = 1'b0;
                        if (!cq_bit) begin
                            falha_next[FALHA_CQ] = 1'b1;
                        end
                    end
                end

                EXIT: begin
                    state_next  = IDLE;
                    idx_next    = idx_seguinte(idx);
                    level_clr   = 1'b1;
                    selada_next = 1'b0;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Registered sensor values are derived from the post-edge state so they
    // track the plant state on the same edge it changes.
    always_comb begin
        if (level_clr) begin
            level_next = '0;
        end else if (level_en) begin
            level_next = level + CNT_W'(1);
        end else begin
            level_next = level;
        end
        garrafa_d = (state_next == AT_FILL) || (state_next == AT_SEAL) || (state_next == AT_CQ);
        nivel_d   = ((state_next == AT_FILL) || (state_next == AT_SEAL)) && (level_next >= FILL_L);
        cq_d      = (state_next == AT_CQ) && CQ_TAB[idx_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            selada          <= 1'b0;
            falha           <= '0;
            garrafa         <= 1'b0;
            sensor_de_nivel <= 1'b0;
            sensor_cq       <= 1'b0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            selada          <= selada_next;
            falha           <= falha_next;
            garrafa         <= garrafa_d;
            sensor_de_nivel <= nivel_d;
            sensor_cq       <= cq_d;
        end
    end

endmodule
